// File: rtl/serial_addsub_if.sv
// Operand/result handshake bundle for serial_addsub.
// The master side is the producer/consumer pair; the slave side is the arithmetic unit.
interface serial_addsub_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;

  modport master (
    output in_valid, a, b, c_in, sub, out_ready,
    input  in_ready, out_valid, sum, c_out, overflow
  );

  modport slave (
    input  in_valid, a, b, c_in, sub, out_ready,
    output in_ready, out_valid, sum, c_out, overflow
  );
endinterface

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: DIGIT full-adder slices per clock, carry held in a register
// between digits, valid/ready on both operand and result sides.
module serial_addsub #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input logic           clk,
  input logic           rst_n,
  serial_addsub_if.slave bus
);
  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = $clog2(NDIG + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [DIGIT:0]   cc;
  logic [DIGIT-1:0] dsum;
  logic             accept, last;

  logic             in_ready_q, out_valid_q, c_out_q, ovf_q;
  logic [WIDTH-1:0] sum_q;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and datapath strobes
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: if (bus.in_valid) begin
        accept    = 1'b1;
        state_nxt = BUSY;
      end
      BUSY: if (cnt == CW'(NDIG - 1)) begin
        last      = 1'b1;
        state_nxt = DONE;
      end
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One digit of chained full-adder slices fed by the carry register
  always_comb begin
    cc    = '0;
    dsum  = '0;
    cc[0] = carry;
    for (int i = 0; i < DIGIT; i++) begin
      dsum[i]  = a_sr[i] ^ b_sr[i] ^ cc[i];
      cc[i+1]  = (a_sr[i] & b_sr[i]) | (b_sr[i] & cc[i]) | (cc[i] & a_sr[i]);
    end
  end

  // New digit enters at the MSB end so the result is aligned after NDIG shifts
  assign res_nxt = (res_sr >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      c_out_q     <= 1'b0;
      ovf_q       <= 1'b0;
      a_sr        <= '0;
      b_sr        <= '0;
      res_sr      <= '0;
      carry       <= 1'b0;
      cnt         <= '0;
    end else begin
      in_ready_q  <= (state_nxt == IDLE);
      out_valid_q <= (state_nxt == DONE);
      if (accept) begin
        // Subtraction as a + ~b + ~c_in
        a_sr  <= bus.a;
        b_sr  <= bus.sub ? ~bus.b : bus.b;
        carry <= bus.c_in ^ bus.sub;
        cnt   <= '0;
      end else if (state == BUSY) begin
        a_sr   <= a_sr >> DIGIT;
        b_sr   <= b_sr >> DIGIT;
        res_sr <= res_nxt;
        carry  <= cc[DIGIT];
        cnt    <= cnt + CW'(1);
      end
      if (last) begin
        sum_q   <= res_nxt;
        c_out_q <= cc[DIGIT];
        ovf_q   <= cc[DIGIT] ^ cc[DIGIT-1];
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.c_out     = c_out_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: DIGIT = 1, 4 and 8 instances checked against an integer
// arithmetic model through a result scoreboard.
module tb_serial_addsub;
  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] d_a, d_b;
  logic       d_c, d_s;
  logic       iv   [3];
  logic       ordy [3];
  logic       o_ir [3];
  logic       o_ov [3];
  logic [7:0] o_sum[3];
  logic       o_co [3];
  logic       o_ovf[3];

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  serial_addsub_if #(.WIDTH(8)) if1 ();
  serial_addsub_if #(.WIDTH(8)) if4 ();
  serial_addsub_if #(.WIDTH(8)) if8 ();

  serial_addsub #(.WIDTH(8), .DIGIT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  serial_addsub #(.WIDTH(8), .DIGIT(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  serial_addsub #(.WIDTH(8), .DIGIT(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

  assign if1.a = d_a;  assign if1.b = d_b;  assign if1.c_in = d_c;  assign if1.sub = d_s;
  assign if4.a = d_a;  assign if4.b = d_b;  assign if4.c_in = d_c;  assign if4.sub = d_s;
  assign if8.a = d_a;  assign if8.b = d_b;  assign if8.c_in = d_c;  assign if8.sub = d_s;
  assign if1.in_valid = iv[0];  assign if1.out_ready = ordy[0];
  assign if4.in_valid = iv[1];  assign if4.out_ready = ordy[1];
  assign if8.in_valid = iv[2];  assign if8.out_ready = ordy[2];

  assign o_ir[0] = if1.in_ready;  assign o_ov[0] = if1.out_valid;  assign o_sum[0] = if1.sum;
  assign o_co[0] = if1.c_out;     assign o_ovf[0] = if1.overflow;
  assign o_ir[1] = if4.in_ready;  assign o_ov[1] = if4.out_valid;  assign o_sum[1] = if4.sum;
  assign o_co[1] = if4.c_out;     assign o_ovf[1] = if4.overflow;
  assign o_ir[2] = if8.in_ready;  assign o_ov[2] = if8.out_valid;  assign o_sum[2] = if8.sum;
  assign o_co[2] = if8.c_out;     assign o_ovf[2] = if8.overflow;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                                 input logic ts);
    exp_t       e;
    logic [8:0] u;
    int         sa, sbv, r;
    sa  = $signed(ta);
    sbv = $signed(tb);
    if (!ts) begin
      u      = 9'(ta) + 9'(tb) + 9'(tc);
      e.cout = u[8];
      r      = sa + sbv + int'(tc);
    end else begin
      u      = 9'(ta) - 9'(tb) - 9'(tc);
      e.cout = ~u[8];
      r      = sa - sbv - int'(tc);
    end
    e.sum = u[7:0];
    e.ovf = (r > 127) || (r < -128);
    return e;
  endfunction

  // One full transaction on instance s: issue, bounded wait, compare, optional backpressure
  task automatic run_op(input int s, input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                        input logic ts, input int lat, input int hold, input bit poke);
    exp_t e;
    int   n;
    @(negedge clk);
    check("idle_in_ready", 32'(o_ir[s]), 1);
    check("idle_out_valid", 32'(o_ov[s]), 0);
    d_a = ta; d_b = tb; d_c = tc; d_s = ts;
    iv[s] = 1'b1;
    sbq.push_back(model(ta, tb, tc, ts));
    @(negedge clk);
    iv[s] = 1'b0;
    n = 0;
    while (o_ov[s] !== 1'b1 && n < 40) begin
      check("busy_in_ready", 32'(o_ir[s]), 0);
      if (poke && n == 1) begin
        d_a = 8'hAA; d_b = 8'h55; iv[s] = 1'b1;
      end else begin
        iv[s] = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    iv[s] = 1'b0;
    check("out_valid_rise", 32'(o_ov[s]), 1);
    check("latency", n, lat);
    check("sb_nonempty", (sbq.size() > 0) ? 1 : 0, 1);
    e = (sbq.size() > 0) ? sbq.pop_front() : '0;
    check("sum", 32'(o_sum[s]), 32'(e.sum));
    check("c_out", 32'(o_co[s]), 32'(e.cout));
    check("overflow", 32'(o_ovf[s]), 32'(e.ovf));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 32'(o_ov[s]), 1);
      check("hold_sum", 32'(o_sum[s]), 32'(e.sum));
      check("hold_c_out", 32'(o_co[s]), 32'(e.cout));
      check("hold_overflow", 32'(o_ovf[s]), 32'(e.ovf));
    end
    ordy[s] = 1'b1;
    @(negedge clk);
    ordy[s] = 1'b0;
    check("post_ack_valid", 32'(o_ov[s]), 0);
    check("post_ack_in_ready", 32'(o_ir[s]), 1);
    check("post_ack_sum_held", 32'(o_sum[s]), 32'(e.sum));
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic       rc, rs;
    rst_n = 1'b0;
    d_a = '0; d_b = '0; d_c = 1'b0; d_s = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; ordy[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_in_ready", 32'(o_ir[i]), 1);
      check("rst_out_valid", 32'(o_ov[i]), 0);
      check("rst_sum", 32'(o_sum[i]), 0);
      check("rst_c_out", 32'(o_co[i]), 0);
      check("rst_overflow", 32'(o_ovf[i]), 0);
    end
    rst_n = 1'b1;

    // Directed add / carry / overflow / subtract cases on DIGIT=1
    run_op(0, 8'h05, 8'h03, 1'b0, 1'b0, 8, 0, 1'b0);
    run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, 8, 0, 1'b0);
    run_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, 8, 0, 1'b0);
    run_op(0, 8'hFF, 8'hFF, 1'b1, 1'b0, 8, 0, 1'b0);
    run_op(0, 8'h07, 8'h07, 1'b0, 1'b1, 8, 0, 1'b0);
    run_op(0, 8'h00, 8'h01, 1'b0, 1'b1, 8, 0, 1'b0);
    run_op(0, 8'h80, 8'h01, 1'b0, 1'b1, 8, 0, 1'b0);
    run_op(0, 8'h00, 8'h80, 1'b1, 1'b1, 8, 0, 1'b0);

    // Backpressure with an in_valid pulse during BUSY
    run_op(0, 8'h3C, 8'h11, 1'b1, 1'b0, 8, 5, 1'b1);
    @(negedge clk);
    check("no_spurious_op", 32'(o_ov[0]), 0);
    check("no_spurious_busy", 32'(o_ir[0]), 1);

    // Reset in the third BUSY cycle aborts the operation
    @(negedge clk);
    d_a = 8'h12; d_b = 8'h34; d_c = 1'b0; d_s = 1'b0;
    iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_in_ready", 32'(o_ir[0]), 1);
    check("abort_out_valid", 32'(o_ov[0]), 0);
    check("abort_sum", 32'(o_sum[0]), 0);
    repeat (10) @(negedge clk);
    check("abort_never_valid", 32'(o_ov[0]), 0);
    run_op(0, 8'h01, 8'h01, 1'b0, 1'b0, 8, 0, 1'b0);

    // Random sweeps
    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      run_op(0, ra, rb, rc, rs, 8, 0, 1'b0);
    end
    for (int i = 0; i < 500; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      run_op(1, ra, rb, rc, rs, 2, (i % 50 == 0) ? 2 : 0, 1'b0);
    end
    for (int i = 0; i < 500; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      run_op(2, ra, rb, rc, rs, 1, (i % 50 == 0) ? 2 : 0, 1'b0);
    end
    run_op(1, 8'h7F, 8'h01, 1'b0, 1'b0, 2, 0, 1'b0);
    run_op(2, 8'h80, 8'h01, 1'b0, 1'b1, 1, 0, 1'b0);

    check("sb_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
